row_scan_sequencer: RTL and testbench

//  Requester side of the SET_ROW_MU/SET_ROW_RO four-phase handshake to the exposure/readout row decoder.
//  Per frame, walks rows row_first..row_last in one channel (MU = mask upload, RO = readout).
//  For each row: presents address, raises SET_ROW, waits DONE, fires a per-row action, then releases.

---
 rtl/row_scan_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_row_scan_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_scan_sequencer.sv
// ---------------------------------------------------------------------------
// row_scan_sequencer
//
// Requester side of the SET_ROW_MU / SET_ROW_RO four-phase handshake towards
// the exposure/readout row decoder. For every frame it walks the rows
// row_first..row_last on one channel (MU = mask upload, RO = readout). Each
// row goes through the same cycle:
//   present address + raise SET_ROW -> wait DONE high -> pulse row_act ->
//   wait row_act_done -> drop SET_ROW -> wait DONE low -> (gap) -> next row
// The walk direction follows the order of row_first/row_last. Row arithmetic
// wraps modulo 2^ADDR_W, and the last serviced row is always row_last.
//
// Optional feature (compile-time macro ROW_TIMEOUT_EN):
//   Adds the T_TIMEOUT input and the sticky error output. A counter bounds
//   the time spent waiting for DONE to rise (S_REQ) or fall (S_REL). When it
//   expires, the request is dropped, error is set and the frame is abandoned
//   without frame_done. Without the macro all waits are unbounded.
//
// Ports
//   clk              in   1       system clock
//   rst              in   1       synchronous active-high reset
//   start            in   1       frame start pulse, ignored while busy
//   mode             in   1       0 = MU channel, 1 = RO channel (sampled with start)
//   row_first        in   ADDR_W  first row (sampled with start)
//   row_last         in   ADDR_W  last row (sampled with start)
//   T_GAP            in   CNT_W   idle cycles between rows (sampled with start)
//   T_TIMEOUT        in   CNT_W   DONE wait limit, 0 = off (ROW_TIMEOUT_EN only)
//   SET_ROW_MU/RO    out  1       row request, only the selected channel
//   ROWADD_MU/RO     out  ADDR_W  row address, 0 while not requesting
//   SET_ROW_DONE_MU  in   1       decoder MU done
//   SET_ROW_DONE_RO  in   1       decoder RO done
//   row_act          out  1       one-cycle pulse: row selected, run per-row work
//   row_act_done     in   1       per-row work complete (level or pulse)
//   cur_row          out  ADDR_W  row being serviced
//   busy             out  1       high from start accept until frame end/abort
//   error            out  1       sticky timeout flag (ROW_TIMEOUT_EN only)
//   frame_done       out  1       one-cycle pulse after the last row released
//
// All outputs are registered and reset to 0.
// ---------------------------------------------------------------------------
module row_scan_sequencer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] row_first,
    input  logic [ADDR_W-1:0] row_last,
    input  logic [CNT_W-1:0]  T_GAP,
`ifdef ROW_TIMEOUT_EN
    input  logic [CNT_W-1:0]  T_TIMEOUT,
`endif
    output logic              SET_ROW_MU,
    output logic              SET_ROW_RO,
    output logic [ADDR_W-1:0] ROWADD_MU,
    output logic [ADDR_W-1:0] ROWADD_RO,
    input  logic              SET_ROW_DONE_MU,
    input  logic              SET_ROW_DONE_RO,
    output logic              row_act,
    input  logic              row_act_done,
    output logic [ADDR_W-1:0] cur_row,
    output logic              busy,
`ifdef ROW_TIMEOUT_EN
    output logic              error,
`endif
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_ACT  = 3'd2,
        S_REL  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t            state_q, state_d;

    // Frame configuration captured when start is accepted
    logic              mode_q, mode_d;
    logic              step_up_q, step_up_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  gap_q, gap_d;

    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

    // Next values of the registered outputs
    logic [ADDR_W-1:0] cur_row_d;
    logic              busy_d;
    logic              row_act_d;
    logic              frame_done_d;
    logic              req_d;
    logic              set_mu_d, set_ro_d;
    logic [ADDR_W-1:0] addr_mu_d, addr_ro_d;

    logic              req_q;
    logic              done_sel;
    logic [ADDR_W-1:0] next_row;
    logic              tmo_hit;

    // Only one channel is ever driven, so the live request is the OR of both.
    assign req_q    = SET_ROW_MU | SET_ROW_RO;

    // The unselected channel's DONE never reaches the state machine.
    assign done_sel = mode_q ? SET_ROW_DONE_RO : SET_ROW_DONE_MU;

    // Wraps modulo 2^ADDR_W; the walk stops on equality with row_last, so a
    // wrap can only happen when row_last genuinely lies beyond the wrap point.
    assign next_row = step_up_q ? cur_row + ADDR_W'(1) : cur_row - ADDR_W'(1);

`ifdef ROW_TIMEOUT_EN
    logic             error_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // tmo_cnt_q holds the number of completed cycles in the current state, so
    // the request is held for exactly T_TIMEOUT cycles before being dropped.
    assign tmo_hit = (T_TIMEOUT != '0) && ((tmo_cnt_q + CNT_W'(1)) == T_TIMEOUT);

    always_comb begin
        tmo_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_REQ) || (state_q == S_REL))) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            error     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            error     <= error_d;
        end
    end
`else
    // No timeout hardware: DONE waits are unbounded.
    assign tmo_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d      = state_q;
        mode_d       = mode_q;
        step_up_d    = step_up_q;
        last_d       = last_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        cur_row_d    = cur_row;
        busy_d       = busy;
        req_d        = req_q;
        row_act_d    = 1'b0;
        frame_done_d = 1'b0;
`ifdef ROW_TIMEOUT_EN
        error_d      = error;
`endif

        case (state_q)
            S_IDLE: begin
                // frame_done is high only in the first idle cycle; a start in
                // that same cycle is deliberately dropped.
                if (start && !frame_done) begin
                    mode_d    = mode;
                    step_up_d = (row_first <= row_last);
                    last_d    = row_last;
                    gap_d     = T_GAP;
                    cur_row_d = row_first;
                    busy_d    = 1'b1;
                    req_d     = 1'b1;
`ifdef ROW_TIMEOUT_EN
                    error_d   = 1'b0;
`endif
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                if (done_sel) begin
                    row_act_d = 1'b1;
                    state_d   = S_ACT;
                end else if (tmo_hit) begin
                    req_d     = 1'b0;
                    busy_d    = 1'b0;
`ifdef ROW_TIMEOUT_EN
                    error_d   = 1'b1;
`endif
                    state_d   = S_IDLE;
                end
            end

            S_ACT: begin
                // row_act is still high during the first S_ACT cycle; a
                // row_act_done seen then belongs to no row yet and is ignored.
                if (!row_act && row_act_done) begin
                    req_d   = 1'b0;
                    state_d = S_REL;
                end
            end

            S_REL: begin
                if (!done_sel) begin
                    if (cur_row == last_q) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        cur_row_d = next_row;
                        if (gap_q == '0) begin
                            req_d   = 1'b1;
                            state_d = S_REQ;
                        end else begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end
                    end
                end else if (tmo_hit) begin
                    busy_d  = 1'b0;
`ifdef ROW_TIMEOUT_EN
                    error_d = 1'b1;
`endif
                    state_d = S_IDLE;
                end
            end

            S_GAP: begin
                // Entered only with gap_q >= 1; stays for exactly gap_q cycles.
                if (gap_cnt_q == (gap_q - CNT_W'(1))) begin
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Route the request onto the selected channel only; the idle channel
        // keeps both its request and its address at 0.
        set_mu_d  = req_d & ~mode_d;
        set_ro_d  = req_d & mode_d;
        addr_mu_d = set_mu_d ? cur_row_d : '0;
        addr_ro_d = set_ro_d ? cur_row_d : '0;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            step_up_q  <= 1'b0;
            last_q     <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            cur_row    <= '0;
            busy       <= 1'b0;
            row_act    <= 1'b0;
            frame_done <= 1'b0;
            SET_ROW_MU <= 1'b0;
            SET_ROW_RO <= 1'b0;
            ROWADD_MU  <= '0;
            ROWADD_RO  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            step_up_q  <= step_up_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            cur_row    <= cur_row_d;
            busy       <= busy_d;
            row_act    <= row_act_d;
            frame_done <= frame_done_d;
            SET_ROW_MU <= set_mu_d;
            SET_ROW_RO <= set_ro_d;
            ROWADD_MU  <= addr_mu_d;
            ROWADD_RO  <= addr_ro_d;
        end
    end

endmodule

// File: tb/tb_row_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_row_scan_sequencer
//
// Scoreboard bench for row_scan_sequencer. Each accepted frame pushes its
// expected row sequence; every row_act pulse pops one entry and compares it
// with cur_row and the selected channel's address. A behavioural decoder and
// per-row worker answer the handshake. Timeout scenarios are compiled in
// when ROW_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_row_scan_sequencer;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] row_first;
    logic [ADDR_W-1:0] row_last;
    logic [CNT_W-1:0]  T_GAP;
    logic [CNT_W-1:0]  T_TIMEOUT;
    logic              SET_ROW_MU, SET_ROW_RO;
    logic [ADDR_W-1:0] ROWADD_MU, ROWADD_RO;
    logic              SET_ROW_DONE_MU, SET_ROW_DONE_RO;
    logic              row_act;
    logic              row_act_done;
    logic [ADDR_W-1:0] cur_row;
    logic              busy;
    logic              error;
    logic              frame_done;

    always #5 clk = ~clk;

    row_scan_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .row_first       (row_first),
        .row_last        (row_last),
        .T_GAP           (T_GAP),
`ifdef ROW_TIMEOUT_EN
        .T_TIMEOUT       (T_TIMEOUT),
`endif
        .SET_ROW_MU      (SET_ROW_MU),
        .SET_ROW_RO      (SET_ROW_RO),
        .ROWADD_MU       (ROWADD_MU),
        .ROWADD_RO       (ROWADD_RO),
        .SET_ROW_DONE_MU (SET_ROW_DONE_MU),
        .SET_ROW_DONE_RO (SET_ROW_DONE_RO),
        .row_act         (row_act),
        .row_act_done    (row_act_done),
        .cur_row         (cur_row),
        .busy            (busy),
`ifdef ROW_TIMEOUT_EN
        .error           (error),
`endif
        .frame_done      (frame_done)
    );

`ifndef ROW_TIMEOUT_EN
    assign error = 1'b0;
`endif

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- environment knobs ----------------
    logic              sel_mode   = 1'b0;  // channel of the frame in flight
    int                done_dly   = 20;    // cycles from SET_ROW rise to DONE rise
    logic              done_en    = 1'b1;  // decoder answers at all
    logic              mu_junk    = 1'b0;  // hold DONE_MU high regardless
    int                act_dly    = 3;     // cycles from row_act to row_act_done pulse
    logic              act_level  = 1'b0;  // hold row_act_done permanently high

    // ---------------- scoreboard and statistics ----------------
    logic [ADDR_W-1:0] exp_q[$];
    int act_cnt, fd_cnt, mu_cyc, ro_cyc, both_cnt, other_nz, mu_rise, min_gap, low_run;
    logic seen_req, prev_sel, prev_mu;

    task automatic clear_stats();
        act_cnt  = 0; fd_cnt   = 0; mu_cyc  = 0; ro_cyc  = 0;
        both_cnt = 0; other_nz = 0; mu_rise = 0; min_gap = 1000;
        low_run  = 0; seen_req = 1'b0;
    endtask

    // Monitor samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin : monitor
        logic sel_req;
        logic sel_done;
        logic [ADDR_W-1:0] sel_addr;
        logic [ADDR_W-1:0] other_addr;
        logic [ADDR_W-1:0] exp_row;
        sel_req    = sel_mode ? SET_ROW_RO      : SET_ROW_MU;
        sel_done   = sel_mode ? SET_ROW_DONE_RO : SET_ROW_DONE_MU;
        sel_addr   = sel_mode ? ROWADD_RO       : ROWADD_MU;
        other_addr = sel_mode ? ROWADD_MU       : ROWADD_RO;

        if (SET_ROW_MU && SET_ROW_RO) both_cnt++;
        if (SET_ROW_MU) mu_cyc++;
        if (SET_ROW_RO) ro_cyc++;
        if (SET_ROW_MU && !prev_mu) mu_rise++;
        if (other_addr != '0) other_nz++;

        if (!sel_req) begin
            low_run++;
        end else begin
            if (!prev_sel && seen_req && low_run < min_gap) min_gap = low_run;
            seen_req = 1'b1;
            low_run  = 0;
        end
        prev_sel = sel_req;
        prev_mu  = SET_ROW_MU;

        if (row_act) begin
            act_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_row_act", 32'(cur_row), 32'hFFFF_FFFF);
            end else begin
                exp_row = exp_q.pop_front();
                check("row_act_cur_row", 32'(cur_row), 32'(exp_row));
                check("row_act_addr", 32'(sel_addr), 32'(exp_row));
                check("row_act_req_high", 32'(sel_req), 32'd1);
            end
        end

        if (frame_done) begin
            fd_cnt++;
            check("frame_done_after_done_low", 32'(sel_done), 32'd0);
        end
    end

    // Behavioural row decoder: DONE rises done_dly cycles after SET_ROW and
    // falls two cycles after SET_ROW is released.
    initial begin : decoder_model
        int hi_mu = 0, lo_mu = 0, hi_ro = 0, lo_ro = 0;
        SET_ROW_DONE_MU = 1'b0;
        SET_ROW_DONE_RO = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (SET_ROW_MU) begin hi_mu++; lo_mu = 0; end else begin lo_mu++; hi_mu = 0; end
            if (SET_ROW_RO) begin hi_ro++; lo_ro = 0; end else begin lo_ro++; hi_ro = 0; end
            if (mu_junk)                                       SET_ROW_DONE_MU = 1'b1;
            else if (SET_ROW_MU && done_en && hi_mu >= done_dly) SET_ROW_DONE_MU = 1'b1;
            else if (!SET_ROW_MU && lo_mu >= 2)                SET_ROW_DONE_MU = 1'b0;
            if (SET_ROW_RO && done_en && hi_ro >= done_dly)    SET_ROW_DONE_RO = 1'b1;
            else if (!SET_ROW_RO && lo_ro >= 2)                SET_ROW_DONE_RO = 1'b0;
        end
    end

    // Per-row worker: pulses row_act_done act_dly cycles after row_act, or
    // holds it high in level mode.
    initial begin : act_model
        int cnt = -1;
        row_act_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (act_level) begin
                row_act_done = 1'b1;
            end else begin
                row_act_done = 1'b0;
                if (row_act) cnt = act_dly;
                else if (cnt > 0) cnt--;
                if (cnt == 0) begin
                    row_act_done = 1'b1;
                    cnt = -1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input logic m, input logic [ADDR_W-1:0] f,
                             input logic [ADDR_W-1:0] l, input int gap);
        logic [ADDR_W-1:0] r;
        r = f;
        forever begin
            exp_q.push_back(r);
            if (r == l) break;
            r = (f <= l) ? r + 10'd1 : r - 10'd1;
        end
        sel_mode  = m;
        mode      = m;
        row_first = f;
        row_last  = l;
        T_GAP     = 32'(gap);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_req", 32'(m ? SET_ROW_RO : SET_ROW_MU), 32'd1);
        check("start_addr", 32'(m ? ROWADD_RO : ROWADD_MU), 32'(f));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin tick(1); n++; end
        if (busy) check(tag, 32'(busy), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        row_first = '0; row_last = '0; T_GAP = '0; T_TIMEOUT = '0;
        prev_sel = 1'b0; prev_mu = 1'b0;
        clear_stats();
        tick(3);
        check("rst_set_row_mu", 32'(SET_ROW_MU), 32'd0);
        check("rst_set_row_ro", 32'(SET_ROW_RO), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_row_act", 32'(row_act), 32'd0);
        check("rst_cur_row", 32'(cur_row), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: RO rows 5..7, no gap, junk DONE on the unused MU channel
        clear_stats();
        done_dly = 20; act_dly = 3; mu_junk = 1'b1;
        run_frame(1'b1, 10'd5, 10'd7, 0);
        wait_idle("t1_frame_end", 2000);
        tick(1);
        check("t1_row_acts", 32'(act_cnt), 32'd3);
        check("t1_frame_done", 32'(fd_cnt), 32'd1);
        check("t1_mu_never_high", 32'(mu_cyc), 32'd0);
        check("t1_rows_left", 32'(exp_q.size()), 32'd0);
        check("t1_other_addr", 32'(other_nz), 32'd0);
        mu_junk = 1'b0;
        tick(4);

        // 2: MU rows 3..1 downward, T_GAP=4
        clear_stats();
        done_dly = 5;
        run_frame(1'b0, 10'd3, 10'd1, 4);
        wait_idle("t2_frame_end", 2000);
        tick(1);
        check("t2_row_acts", 32'(act_cnt), 32'd3);
        check("t2_frame_done", 32'(fd_cnt), 32'd1);
        check("t2_ro_never_high", 32'(ro_cyc), 32'd0);
        check("t2_gap_ge_4", 32'(min_gap >= 4), 32'd1);
        check("t2_rows_left", 32'(exp_q.size()), 32'd0);
        tick(4);

        // 3: single row 9..9, row_act_done held high; start during frame_done
        clear_stats();
        act_level = 1'b1;
        run_frame(1'b0, 10'd9, 10'd9, 0);
        begin : t3_wait
            int n;
            n = 0;
            while (!frame_done && n < 2000) begin tick(1); n++; end
            check("t3_frame_done_seen", 32'(frame_done), 32'd1);
        end
        act_level = 1'b0;
        start = 1'b1;               // coincides with the frame_done cycle
        tick(1);
        start = 1'b0;
        check("t3_start_on_fd_ignored", 32'(busy), 32'd0);
        tick(5);
        check("t3_single_request", 32'(mu_rise), 32'd1);
        check("t3_row_acts", 32'(act_cnt), 32'd1);
        check("t3_frame_done", 32'(fd_cnt), 32'd1);
        check("t3_still_idle", 32'(busy), 32'd0);
        check("t3_rows_left", 32'(exp_q.size()), 32'd0);

        // 4: start re-pulsed with new config during row 2 of 0..3
        clear_stats();
        run_frame(1'b1, 10'd0, 10'd3, 2);
        begin : t4_wait
            int n;
            n = 0;
            while (!(cur_row == 10'd2 && SET_ROW_RO) && n < 2000) begin tick(1); n++; end
            check("t4_reached_row2", 32'(cur_row), 32'd2);
        end
        mode = 1'b0; row_first = 10'd100; row_last = 10'd100; T_GAP = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("t4_frame_end", 3000);
        tick(1);
        check("t4_row_acts", 32'(act_cnt), 32'd4);
        check("t4_frame_done", 32'(fd_cnt), 32'd1);
        check("t4_mu_never_high", 32'(mu_cyc), 32'd0);
        check("t4_rows_left", 32'(exp_q.size()), 32'd0);
        tick(4);

        // 5: reset while in S_ACT, then a fresh frame
        clear_stats();
        run_frame(1'b0, 10'd0, 10'd5, 0);
        begin : t5_wait
            int n;
            n = 0;
            while (!row_act && n < 2000) begin tick(1); n++; end
            check("t5_row_act_seen", 32'(row_act), 32'd1);
        end
        rst = 1'b1;
        tick(1);
        check("t5_rst_set_row_mu", 32'(SET_ROW_MU), 32'd0);
        check("t5_rst_set_row_ro", 32'(SET_ROW_RO), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_row_act", 32'(row_act), 32'd0);
        check("t5_rst_addr", 32'(ROWADD_MU), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        tick(10);
        clear_stats();
        run_frame(1'b1, 10'd2, 10'd3, 0);
        wait_idle("t5_frame_end", 2000);
        tick(1);
        check("t5_row_acts", 32'(act_cnt), 32'd2);
        check("t5_frame_done", 32'(fd_cnt), 32'd1);
        check("t5_rows_left", 32'(exp_q.size()), 32'd0);
        tick(4);

`ifdef ROW_TIMEOUT_EN
        // 6: decoder never answers, T_TIMEOUT=50
        clear_stats();
        T_TIMEOUT = 32'd50;
        done_en   = 1'b0;
        run_frame(1'b0, 10'd4, 10'd6, 0);
        wait_idle("t6_abort", 500);
        tick(1);
        exp_q.delete();
        check("t6_req_cycles", 32'(mu_cyc), 32'd50);
        check("t6_error", 32'(error), 32'd1);
        check("t6_no_frame_done", 32'(fd_cnt), 32'd0);
        check("t6_no_row_act", 32'(act_cnt), 32'd0);
        check("t6_req_dropped", 32'(SET_ROW_MU), 32'd0);
        tick(5);
        check("t6_error_sticky", 32'(error), 32'd1);
        clear_stats();
        done_en  = 1'b1;
        done_dly = 5;
        run_frame(1'b0, 10'd4, 10'd5, 0);
        check("t6_error_cleared", 32'(error), 32'd0);
        wait_idle("t6_frame_end", 2000);
        tick(1);
        check("t6_row_acts", 32'(act_cnt), 32'd2);
        check("t6_frame_done", 32'(fd_cnt), 32'd1);
        check("t6_error_stays_clear", 32'(error), 32'd0);
`endif

        // Channel exclusivity over the whole run is covered per test; check
        // the last window too.
        check("never_both_high", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
